// File: rtl/fxp_addsub_acc.sv
// Streaming saturating add/subtract accumulator: one clamped N-bit result per s_last-terminated burst.
// Latency: result valid on the cycle after the s_last handshake.
// Backpressure: s_ready drops while a result waits for m_ready, so one bubble cycle separates bursts.
//
// Ports:
//   clk, rst             clock and asynchronous active-high reset
//   s_valid/s_ready      sample handshake; s_data signed sample, s_sub selects subtract, s_last ends burst
//   m_valid/m_ready      result handshake; m_data clamped sum, m_sat sticky saturation, m_count samples seen
module fxp_addsub_acc #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [N-1:0]         s_data,
    input  logic                 s_sub,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [N-1:0]         m_data,
    output logic                 m_sat,
    output logic [CNT_W-1:0]     m_count
);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam logic [N-1:0]     MAX_VAL = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]     MIN_VAL = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_nxt;

    logic [N-1:0]      acc;
    logic              sat;
    logic [CNT_W-1:0]  cnt;

    logic [N:0]        ext_acc;
    logic [N:0]        ext_dat;
    logic [N:0]        sum;
    logic [N-1:0]      clamped;
    logic              step_sat;
    logic [CNT_W-1:0]  cnt_inc;
    logic              take;
    logic              give;

    // Both handshake outputs come straight from the state flop, so no input
    // can reach them combinationally and reset clears m_valid immediately.
    assign s_ready = (state == ST_ACC);
    assign m_valid = (state == ST_OUT);

    assign take = s_valid && s_ready;
    assign give = m_valid && m_ready;

    // One guard bit keeps the true sum, including 0 - (most negative value).
    assign ext_acc = {acc[N-1], acc};
    assign ext_dat = {s_data[N-1], s_data};
    assign sum     = s_sub ? (ext_acc - ext_dat) : (ext_acc + ext_dat);

    // Guard bit disagreeing with the N-bit sign bit means the sum left the
    // representable range; the guard bit tells which rail to pin to.
    always_comb begin
        clamped  = sum[N-1:0];
        step_sat = 1'b0;
        if (sum[N] != sum[N-1]) begin
            step_sat = 1'b1;
            clamped  = sum[N] ? MIN_VAL : MAX_VAL;
        end
    end

    // Counter pins at all-ones instead of wrapping.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : (cnt + CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC:  if (take && s_last) state_nxt = ST_OUT;
            ST_OUT:  if (m_ready)        state_nxt = ST_ACC;
            default:                     state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            sat     <= 1'b0;
            cnt     <= '0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            m_count <= '0;
        end else begin
            if (take) begin
                acc <= clamped;
                sat <= sat | step_sat;
                cnt <= cnt_inc;
                if (s_last) begin
                    m_data  <= clamped;
                    m_sat   <= sat | step_sat;
                    m_count <= cnt_inc;
                end
            end
            // Result leaves: start the next burst from zero. The result
            // registers keep their values; they are ignored while m_valid=0.
            if (give) begin
                acc <= '0;
                sat <= 1'b0;
                cnt <= '0;
            end
        end
    end

endmodule
